bitserial_mac_ctrl: RTL and testbench

Sequencer and accumulator for the bit-serial MAC datapath. It accepts a stream of (activation, weight) pairs and steps through each weight one bit per cycle, LSB first. Each cycle it forms the AND of the activation with the selected weight bit, shifts that partial product to the bit position, and accumulates it. After a programmed number of pairs it presents the dot product on a valid/ready result port. It sits between the operand buffers and the output writeback. Precision is selectable per job (8/4/2-bit weights).

---
 rtl/bsmac_pkg.sv | 26 ++
 rtl/bitserial_pe.sv | 26 ++
 rtl/bitserial_mac_ctrl.sv | 118 +++++++++++
 tb/tb_bitserial_mac_ctrl.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsmac_pkg.sv
// Shared types and helpers for the bit-serial MAC controller.
package bsmac_pkg;

    typedef enum logic [1:0] {
        PREC8 = 2'b00,
        PREC4 = 2'b01,
        PREC2 = 2'b10
    } prec_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        OUT
    } state_e;

    // Encoding 11 falls through to 8 bits on purpose.
    function automatic logic [3:0] prec_bits(input logic [1:0] prec);
        case (prec_e'(prec))
            PREC4:   prec_bits = 4'd4;
            PREC2:   prec_bits = 4'd2;
            default: prec_bits = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/bitserial_pe.sv
// Combinational partial-product unit: masks the activation with one weight bit and shifts it into place.
// BSMAC_SIGNED_EN selects sign extension of the activation; neg negates the shifted product.
module bitserial_pe #(
    parameter int ACC_W = 20
) (
    input  logic [7:0]       act,
    input  logic             wbit,
    input  logic [2:0]       bit_idx,
    input  logic             neg,
    output logic [ACC_W-1:0] pp
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] shifted;

    always_comb begin
`ifdef BSMAC_SIGNED_EN
        ext = {{(ACC_W-8){act[7]}}, act};
`else
        ext = {{(ACC_W-8){1'b0}}, act};
`endif
        shifted = wbit ? (ext << bit_idx) : '0;
        pp      = neg ? ('0 - shifted) : shifted;
    end

endmodule

// File: rtl/bitserial_mac_ctrl.sv
// Bit-serial MAC sequencer: fetches (act, wgt) pairs, accumulates one weight bit per cycle, presents the dot product.
// Optional BSMAC_SIGNED_EN: two's complement operands, MSB partial product subtracted.
module bitserial_mac_ctrl
    import bsmac_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       prec,
    input  logic [LEN_W-1:0] vlen,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       act,
    input  logic [7:0]       wgt,
    output logic [2:0]       bit_idx,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res
);

    state_e           state;
    state_e           state_nxt;
    logic [3:0]       p_q;
    logic [LEN_W-1:0] vlen_q;
    logic [LEN_W-1:0] pc;
    logic [7:0]       act_q;
    logic [7:0]       wgt_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] pp;
    logic             last_bit;
    logic             neg;

    assign last_bit = ({1'b0, bit_idx} == (p_q - 4'd1));

`ifdef BSMAC_SIGNED_EN
    assign neg = last_bit;
`else
    assign neg = 1'b0;
`endif

    bitserial_pe #(.ACC_W(ACC_W)) u_pe (
        .act     (act_q),
        .wbit    (wgt_q[bit_idx]),
        .bit_idx (bit_idx),
        .neg     (neg),
        .pp      (pp)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start)     state_nxt = FETCH;
            FETCH: if (in_valid)  state_nxt = SHIFT;
            SHIFT: if (last_bit)  state_nxt = (pc == vlen_q) ? OUT : FETCH;
            OUT:   if (res_ready) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == FETCH);
        busy      = (state != IDLE);
        res_valid = (state == OUT);
    end

    // Job parameters are captured once at start so mid-job input changes are harmless.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= '0;
            pc      <= '0;
            bit_idx <= '0;
            p_q     <= 4'd8;
            vlen_q  <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        pc     <= '0;
                        p_q    <= prec_bits(prec);
                        vlen_q <= vlen;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        act_q   <= act;
                        wgt_q   <= wgt;
                        bit_idx <= '0;
                    end
                end
                SHIFT: begin
                    acc <= acc + pp;
                    if (last_bit) begin
                        bit_idx <= '0;
                        if (pc != vlen_q) pc <= pc + 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res = acc;

endmodule

// File: tb/tb_bitserial_mac_ctrl.sv
// Scoreboard bench for bitserial_mac_ctrl: expected dot products are queued as jobs are driven.
module tb_bitserial_mac_ctrl;

    localparam int ACC_W = 20;
    localparam int LEN_W = 4;
    localparam int BOUND = 300;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       prec = 2'b00;
    logic [LEN_W-1:0] vlen = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       act = '0;
    logic [7:0]       wgt = '0;
    logic [2:0]       bit_idx;
    logic             busy;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [ACC_W-1:0] res;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [ACC_W-1:0] exp_q[$];
    logic [2:0]       bidx_q[$];
    logic [7:0]       job_act[16];
    logic [7:0]       job_wgt[16];

    bitserial_mac_ctrl #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .prec      (prec),
        .vlen      (vlen),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act       (act),
        .wgt       (wgt),
        .bit_idx   (bit_idx),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log bit_idx for every cycle the controller sits in its shift phase.
    always @(negedge clk)
        if (rstn && busy && !in_ready && !res_valid) bidx_q.push_back(bit_idx);

    function automatic logic [ACC_W-1:0] model(input logic [1:0] p, input int n);
        int s;
        int pb;
        int a;
        int w;
        logic [7:0] wm;
        s  = 0;
        pb = (p == 2'b01) ? 4 : (p == 2'b10) ? 2 : 8;
        for (int i = 0; i < n; i++) begin
`ifdef BSMAC_SIGNED_EN
            a  = int'($signed(job_act[i]));
            wm = job_wgt[i] << (8 - pb);
            w  = int'($signed(wm));
            w  = w >>> (8 - pb);
`else
            a  = int'(job_act[i]);
            w  = int'(job_wgt[i]) & ((1 << pb) - 1);
`endif
            s += a * w;
        end
        return s[ACC_W-1:0];
    endfunction

    task automatic run_job(input logic [1:0] p, input int n, output logic timed_out, output int lat);
        int c0;
        int guard;
        timed_out = 1'b0;
        exp_q.push_back(model(p, n));
        prec  = p;
        vlen  = LEN_W'(n - 1);
        start = 1'b1;
        c0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        prec  = 2'($urandom);
        vlen  = LEN_W'($urandom);
        for (int i = 0; i < n; i++) begin
            act      = job_act[i];
            wgt      = job_wgt[i];
            in_valid = 1'b1;
            guard    = 0;
            while (!in_ready && guard < BOUND) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= BOUND) timed_out = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        guard = 0;
        while (!res_valid && guard < BOUND) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= BOUND) timed_out = 1'b1;
        lat = cyc - c0;
    endtask

    task automatic finish_result();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        n_cmp++;
        if ({in_ready, busy, res_valid} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {in_ready, busy, res_valid});
        end
        n_cmp++;
        if (res !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_res: got %0h expected 0", res);
        end
        n_cmp++;
        if (bit_idx !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_bit_idx: got %0d expected 0", bit_idx);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_prec8();
        logic to;
        int lat;
        logic [ACC_W-1:0] e;
        job_act[0] = 8'h0B;
        job_wgt[0] = 8'h09;
        run_job(2'b00, 1, to, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || res !== e) begin
            n_fail++;
            $display("[TB] FAIL prec8_res: got %0d expected %0d (timeout %b)", res, e, to);
        end
        n_cmp++;
        if (lat !== 10) begin
            n_fail++;
            $display("[TB] FAIL prec8_latency: got %0d expected 10", lat);
        end
        finish_result();
    endtask

    task automatic test_prec4();
        logic to;
        int lat;
        logic [ACC_W-1:0] e;
        job_act[0] = 8'hFF; job_wgt[0] = 8'h0F;
        job_act[1] = 8'h10; job_wgt[1] = 8'h05;
        job_act[2] = 8'h03; job_wgt[2] = 8'hF2;
        run_job(2'b01, 3, to, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || res !== e) begin
            n_fail++;
            $display("[TB] FAIL prec4_res: got %0d expected %0d (timeout %b)", res, e, to);
        end
        n_cmp++;
        if (lat !== 1 + 3 * 5) begin
            n_fail++;
            $display("[TB] FAIL prec4_latency: got %0d expected 16", lat);
        end
        finish_result();
    endtask

    task automatic test_prec2();
        logic to;
        int lat;
        logic [ACC_W-1:0] e;
        for (int i = 0; i < 4; i++) begin
            job_act[i] = 8'h55;
            job_wgt[i] = 8'h03;
        end
        bidx_q.delete();
        run_job(2'b10, 4, to, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || res !== e) begin
            n_fail++;
            $display("[TB] FAIL prec2_res: got %0d expected %0d (timeout %b)", res, e, to);
        end
        n_cmp++;
        if (bidx_q.size() !== 8) begin
            n_fail++;
            $display("[TB] FAIL prec2_shift_cycles: got %0d expected 8", bidx_q.size());
        end
        for (int i = 0; i < bidx_q.size() && i < 8; i++) begin
            n_cmp++;
            if (bidx_q[i] !== 3'(i % 2)) begin
                n_fail++;
                $display("[TB] FAIL prec2_bit_idx[%0d]: got %0d expected %0d", i, bidx_q[i], i % 2);
            end
        end
        finish_result();
    endtask

    task automatic test_backpressure();
        logic to;
        int lat;
        logic [ACC_W-1:0] e;
        job_act[0] = 8'hC3; job_wgt[0] = 8'hA7;
        job_act[1] = 8'h7E; job_wgt[1] = 8'h5B;
        run_job(2'b11, 2, to, lat);
        e = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (to !== 1'b0 || res_valid !== 1'b1 || res !== e) begin
                n_fail++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b res=%0d expected valid=1 res=%0d", c, res_valid, res, e);
            end
            start = (c == 2);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        finish_result();
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL start_not_queued%0d: got busy=%b expected 0", c, busy);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        int guard;
        logic [ACC_W-1:0] part;
        logic [ACC_W-1:0] e;
        job_act[0] = 8'h2D; job_wgt[0] = 8'h0B;
        job_act[1] = 8'h91; job_wgt[1] = 8'h06;
        part = model(2'b01, 1);
        exp_q.push_back(model(2'b01, 2));
        prec  = 2'b01;
        vlen  = LEN_W'(1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        act      = job_act[0];
        wgt      = job_wgt[0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        act      = 8'hFF;
        wgt      = 8'hFF;
        guard    = 0;
        while (!in_ready && guard < BOUND) begin
            @(posedge clk);
            #1;
            guard++;
        end
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (in_ready !== 1'b1 || res !== part) begin
                n_fail++;
                $display("[TB] FAIL stall_acc%0d: got ready=%b acc=%0d expected ready=1 acc=%0d", c, in_ready, res, part);
            end
            @(posedge clk);
            #1;
        end
        act      = job_act[1];
        wgt      = job_wgt[1];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        guard    = 0;
        while (!res_valid && guard < BOUND) begin
            @(posedge clk);
            #1;
            guard++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (res_valid !== 1'b1 || res !== e) begin
            n_fail++;
            $display("[TB] FAIL stall_res: got valid=%b res=%0d expected valid=1 res=%0d", res_valid, res, e);
        end
        finish_result();
    endtask

    task automatic test_reset_mid();
        int guard;
        logic to;
        int lat;
        logic [ACC_W-1:0] e;
        prec  = 2'b00;
        vlen  = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        act      = 8'hFF;
        wgt      = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        guard    = 0;
        while (bit_idx !== 3'd3 && guard < BOUND) begin
            @(posedge clk);
            #1;
            guard++;
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (guard >= BOUND || busy !== 1'b0 || in_ready !== 1'b0 || res !== '0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got busy=%b ready=%b res=%0d expected 0/0/0", busy, in_ready, res);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        job_act[0] = 8'h0B;
        job_wgt[0] = 8'h09;
        run_job(2'b00, 1, to, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || res !== e) begin
            n_fail++;
            $display("[TB] FAIL after_reset_res: got %0d expected %0d", res, e);
        end
        finish_result();
    endtask

    task automatic test_back_to_back();
        logic to;
        int lat;
        int n;
        logic [1:0] p;
        logic [ACC_W-1:0] e;
        for (int j = 0; j < 5; j++) begin
            p = 2'($urandom_range(0, 3));
            n = (j == 0) ? 16 : $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                job_act[i] = 8'($urandom);
                job_wgt[i] = 8'($urandom);
            end
            run_job(p, n, to, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (to !== 1'b0 || res !== e) begin
                n_fail++;
                $display("[TB] FAIL b2b_job%0d: got %0d expected %0d (prec %0d, pairs %0d)", j, res, e, p, n);
            end
            finish_result();
        end
    endtask

`ifdef BSMAC_SIGNED_EN
    task automatic test_signed();
        logic to;
        int lat;
        logic [ACC_W-1:0] e;
        job_act[0] = 8'h05;
        job_wgt[0] = 8'h0E;
        run_job(2'b01, 1, to, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || res !== e || res !== 20'hFFFF6) begin
            n_fail++;
            $display("[TB] FAIL signed_res: got %0h expected FFFF6", res);
        end
        finish_result();
    endtask
`endif

    initial begin
        test_reset();
        test_prec8();
        test_prec4();
        test_prec2();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef BSMAC_SIGNED_EN
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
